// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage sitting directly after the execute stage.
// Registers the execute results, runs one load/store per instruction over a
// req/ack handshake to data memory, and hands write-back data and controls to
// the write-back stage. While an access is outstanding the upstream pipeline
// is stalled. Misaligned accesses and accesses that are never acknowledged are
// aborted with a one-cycle error pulse.
//
// Parameters
//   TIMEOUT     : request cycles without ack before the access is aborted (1..255)
//   CHECK_ALIGN : 1 = memory ops must be word aligned, 0 = no alignment check
//
// Ports
//   clk, rstn                : clock, asynchronous active-low reset
//   i_MEM_dmemWe/regWe/sWD   : store enable, reg write enable, load select
//   i_MEM_WRA                : destination register address
//   i_MEM_ALUout             : ALU result / memory byte address
//   i_MEM_wdata              : store data
//   o_dmem_req/we/addr/wdata : data-memory request channel
//   i_dmem_ack, i_dmem_rdata : data-memory completion and read data
//   o_MEM_regWe/WRA/WD       : write-back controls and data
//   o_MEM_stall              : upstream must hold, this stage does not load
//   o_MEM_err                : one-cycle pulse on an aborted access
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int TIMEOUT     = 15,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        i_MEM_dmemWe,
    input  logic        i_MEM_regWe,
    input  logic        i_MEM_sWD,
    input  logic [4:0]  i_MEM_WRA,
    input  logic [31:0] i_MEM_ALUout,
    input  logic [31:0] i_MEM_wdata,

    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,

    output logic        o_MEM_regWe,
    output logic [4:0]  o_MEM_WRA,
    output logic [31:0] o_MEM_WD,
    output logic        o_MEM_stall,
    output logic        o_MEM_err
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    // -------------------------------------------------------------------------
    // Stage register
    // -------------------------------------------------------------------------
    logic        dmem_we_reg;
    logic        reg_we_reg;
    logic        swd_reg;
    logic [4:0]  wra_reg;
    logic [31:0] alu_out_reg;
    logic [31:0] wdata_reg;

    // -------------------------------------------------------------------------
    // Access FSM
    // -------------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  wait_cnt_reg;
    logic [7:0]  wait_cnt_next;

    logic        memop;
    logic        mis;
    logic        timed_out;

    logic        req;
    logic        stall;
    logic        reg_we_out;
    logic        err;

    // The stage register only advances when this stage is not stalling, so
    // the instruction (and hence addr/we/wdata) stays put for the whole
    // transaction. stall depends on ack combinationally, which lets the next
    // instruction load in the very cycle the ack arrives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dmem_we_reg <= 1'b0;
            reg_we_reg  <= 1'b0;
            swd_reg     <= 1'b0;
            wra_reg     <= 5'd0;
            alu_out_reg <= 32'd0;
            wdata_reg   <= 32'd0;
        end else if (!stall) begin
            dmem_we_reg <= i_MEM_dmemWe;
            reg_we_reg  <= i_MEM_regWe;
            swd_reg     <= i_MEM_sWD;
            wra_reg     <= i_MEM_WRA;
            alu_out_reg <= i_MEM_ALUout;
            wdata_reg   <= i_MEM_wdata;
        end
    end

    assign memop     = dmem_we_reg | swd_reg;
    assign mis       = CHECK_ALIGN && memop && (alu_out_reg[1:0] != 2'b00);
    // The >= (rather than ==) keeps the abort reachable even if the counter
    // were ever to sit above the limit.
    assign timed_out = (wait_cnt_reg >= TIMEOUT_CNT);

    always_comb begin
        req           = 1'b0;
        stall         = 1'b0;
        reg_we_out    = 1'b0;
        err           = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;

        case (state_reg)
            RUN: begin
                if (!memop) begin
                    // Plain ALU instruction: straight through in one cycle.
                    reg_we_out = reg_we_reg;
                end else if (mis) begin
                    // Misaligned: drop the instruction, never touch memory.
                    err = 1'b1;
                end else begin
                    req = 1'b1;
                    if (i_dmem_ack) begin
                        // Zero-wait completion.
                        reg_we_out = reg_we_reg;
                    end else begin
                        stall         = 1'b1;
                        state_next    = WAIT;
                        wait_cnt_next = 8'd1;
                    end
                end
            end

            WAIT: begin
                if (timed_out) begin
                    // Abort: request withdrawn, any ack this cycle is ignored.
                    err           = 1'b1;
                    state_next    = RUN;
                    wait_cnt_next = 8'd0;
                end else begin
                    req = 1'b1;
                    if (i_dmem_ack) begin
                        reg_we_out    = reg_we_reg;
                        state_next    = RUN;
                        wait_cnt_next = 8'd0;
                    end else begin
                        stall = 1'b1;
                        // Saturating increment: never wraps back below limit.
                        if (wait_cnt_reg != 8'hFF) begin
                            wait_cnt_next = wait_cnt_reg + 8'd1;
                        end
                    end
                end
            end

            default: begin
                state_next    = RUN;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (combinational from the registers and the ack/rdata inputs)
    // -------------------------------------------------------------------------
    assign o_dmem_req   = req;
    assign o_dmem_we    = dmem_we_reg;
    assign o_dmem_addr  = alu_out_reg;
    assign o_dmem_wdata = wdata_reg;

    assign o_MEM_regWe  = reg_we_out;
    assign o_MEM_WRA    = wra_reg;
    assign o_MEM_WD     = swd_reg ? i_dmem_rdata : alu_out_reg;
    assign o_MEM_stall  = stall;
    assign o_MEM_err    = err;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage. Stimulus pushes the expected write-back
// (or abort) of each instruction into a scoreboard queue; a monitor pops and
// compares whenever the stage presents a write-back or an error pulse.
// Cycle-level handshake behaviour is checked directly by the stimulus thread.
// A second instance with the alignment check disabled shares the stimulus.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        rstn;
    logic        i_MEM_dmemWe;
    logic        i_MEM_regWe;
    logic        i_MEM_sWD;
    logic [4:0]  i_MEM_WRA;
    logic [31:0] i_MEM_ALUout;
    logic [31:0] i_MEM_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;

    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic        o_MEM_regWe;
    logic [4:0]  o_MEM_WRA;
    logic [31:0] o_MEM_WD;
    logic        o_MEM_stall;
    logic        o_MEM_err;

    logic        na_dmem_req;
    logic        na_dmem_we;
    logic [31:0] na_dmem_addr;
    logic [31:0] na_dmem_wdata;
    logic        na_MEM_regWe;
    logic [4:0]  na_MEM_WRA;
    logic [31:0] na_MEM_WD;
    logic        na_MEM_stall;
    logic        na_MEM_err;

    typedef struct packed {
        logic        err;
        logic [4:0]  wra;
        logic [31:0] wd;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    mem_stage #(.TIMEOUT(4), .CHECK_ALIGN(1'b1)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_MEM_dmemWe (i_MEM_dmemWe),
        .i_MEM_regWe  (i_MEM_regWe),
        .i_MEM_sWD    (i_MEM_sWD),
        .i_MEM_WRA    (i_MEM_WRA),
        .i_MEM_ALUout (i_MEM_ALUout),
        .i_MEM_wdata  (i_MEM_wdata),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .o_MEM_regWe  (o_MEM_regWe),
        .o_MEM_WRA    (o_MEM_WRA),
        .o_MEM_WD     (o_MEM_WD),
        .o_MEM_stall  (o_MEM_stall),
        .o_MEM_err    (o_MEM_err)
    );

    mem_stage #(.TIMEOUT(4), .CHECK_ALIGN(1'b0)) dut_na (
        .clk          (clk),
        .rstn         (rstn),
        .i_MEM_dmemWe (i_MEM_dmemWe),
        .i_MEM_regWe  (i_MEM_regWe),
        .i_MEM_sWD    (i_MEM_sWD),
        .i_MEM_WRA    (i_MEM_WRA),
        .i_MEM_ALUout (i_MEM_ALUout),
        .i_MEM_wdata  (i_MEM_wdata),
        .o_dmem_req   (na_dmem_req),
        .o_dmem_we    (na_dmem_we),
        .o_dmem_addr  (na_dmem_addr),
        .o_dmem_wdata (na_dmem_wdata),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .o_MEM_regWe  (na_MEM_regWe),
        .o_MEM_WRA    (na_MEM_WRA),
        .o_MEM_WD     (na_MEM_WD),
        .o_MEM_stall  (na_MEM_stall),
        .o_MEM_err    (na_MEM_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic rwe, input logic swd,
                         input logic [4:0] wra, input logic [31:0] alu,
                         input logic [31:0] wd);
        i_MEM_dmemWe = we;
        i_MEM_regWe  = rwe;
        i_MEM_sWD    = swd;
        i_MEM_WRA    = wra;
        i_MEM_ALUout = alu;
        i_MEM_wdata  = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic push(input logic err, input logic [4:0] wra, input logic [31:0] wd);
        sb_entry_t e;
        e.err = err;
        e.wra = wra;
        e.wd  = wd;
        sb_q.push_back(e);
    endtask

    // Monitor: one line per write-back or abort event.
    always @(negedge clk) begin : monitor
        sb_entry_t e;
        if (rstn === 1'b1 && (o_MEM_regWe === 1'b1 || o_MEM_err === 1'b1)) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected regWe=%0b err=%0b wra=%0d wd=0x%08h expected=none",
                         o_MEM_regWe, o_MEM_err, o_MEM_WRA, o_MEM_WD);
            end else begin
                e = sb_q.pop_front();
                $display("txn t=%0t regWe=%0b err=%0b wra=%0d wd=0x%08h", $time,
                         o_MEM_regWe, o_MEM_err, o_MEM_WRA, o_MEM_WD);
                if (e.err) begin
                    chk("sb_err", 32'(o_MEM_err), 32'd1);
                    chk("sb_err_regwe", 32'(o_MEM_regWe), 32'd0);
                end else begin
                    chk("sb_regwe", 32'(o_MEM_regWe), 32'd1);
                    chk("sb_noerr", 32'(o_MEM_err), 32'd0);
                    chk("sb_wra", 32'(o_MEM_WRA), 32'(e.wra));
                    chk("sb_wd", o_MEM_WD, e.wd);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rstn         = 1'b0;
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hFFFF_FFFF;
        drive(1'b1, 1'b1, 1'b1, 5'd31, 32'h0000_0100, 32'h1111_1111);

        // Reset state: every output zero while the stage register is cleared.
        #8;
        chk("rst_req", 32'(o_dmem_req), 32'd0);
        chk("rst_stall", 32'(o_MEM_stall), 32'd0);
        chk("rst_regwe", 32'(o_MEM_regWe), 32'd0);
        chk("rst_err", 32'(o_MEM_err), 32'd0);
        chk("rst_addr", o_dmem_addr, 32'd0);
        chk("rst_wd", o_MEM_WD, 32'd0);
        chk("rst_wra", 32'(o_MEM_WRA), 32'd0);
        i_dmem_ack = 1'b0;
        idle();
        #4 rstn = 1'b1;
        tick();

        // 1. ALU op, one cycle latency.
        drive(1'b0, 1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'd0);
        push(1'b0, 5'd5, 32'h0000_1234);
        tick();
        idle();
        @(negedge clk);
        chk("t1_req", 32'(o_dmem_req), 32'd0);
        chk("t1_stall", 32'(o_MEM_stall), 32'd0);
        tick();

        // 2. Zero-wait load.
        drive(1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'd0);
        push(1'b0, 5'd7, 32'hDEAD_BEEF);
        tick();
        idle();
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_req", 32'(o_dmem_req), 32'd1);
        chk("t2_we", 32'(o_dmem_we), 32'd0);
        chk("t2_addr", o_dmem_addr, 32'h0000_0100);
        chk("t2_stall", 32'(o_MEM_stall), 32'd0);
        tick();
        i_dmem_ack = 1'b0;
        @(negedge clk);
        chk("t2_regwe_once", 32'(o_MEM_regWe), 32'd0);
        chk("t2_req_off", 32'(o_dmem_req), 32'd0);
        tick();

        // 3. Store with three wait cycles; next ALU op is held upstream.
        drive(1'b1, 1'b0, 1'b0, 5'd1, 32'h0000_0040, 32'hA5A5_A5A5);
        tick();
        drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_0099, 32'd0);
        push(1'b0, 5'd9, 32'h0000_0099);
        for (int i = 0; i < 4; i++) begin
            i_dmem_ack = (i == 3);
            @(negedge clk);
            chk("t3_req", 32'(o_dmem_req), 32'd1);
            chk("t3_stall", 32'(o_MEM_stall), (i < 3) ? 32'd1 : 32'd0);
            chk("t3_we", 32'(o_dmem_we), 32'd1);
            chk("t3_addr", o_dmem_addr, 32'h0000_0040);
            chk("t3_wdata", o_dmem_wdata, 32'hA5A5_A5A5);
            chk("t3_regwe", 32'(o_MEM_regWe), 32'd0);
            tick();
        end
        i_dmem_ack = 1'b0;
        idle();
        @(negedge clk);
        chk("t3_next_req", 32'(o_dmem_req), 32'd0);
        chk("t3_next_wra", 32'(o_MEM_WRA), 32'd9);
        tick();

        // 4. Timeout on an unacknowledged load (TIMEOUT=4).
        drive(1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0200, 32'd0);
        push(1'b1, 5'd3, 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 5'd4, 32'h0000_0044, 32'd0);
        push(1'b0, 5'd4, 32'h0000_0044);
        i_dmem_rdata = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            i_dmem_ack = (i == 4);   // late ack must be ignored
            @(negedge clk);
            if (i < 4) begin
                chk("t4_req", 32'(o_dmem_req), 32'd1);
                chk("t4_stall", 32'(o_MEM_stall), 32'd1);
                chk("t4_regwe", 32'(o_MEM_regWe), 32'd0);
            end else begin
                chk("t4_abort_req", 32'(o_dmem_req), 32'd0);
                chk("t4_abort_stall", 32'(o_MEM_stall), 32'd0);
                chk("t4_abort_err", 32'(o_MEM_err), 32'd1);
                chk("t4_abort_regwe", 32'(o_MEM_regWe), 32'd0);
            end
            tick();
        end
        i_dmem_ack = 1'b0;
        idle();
        @(negedge clk);
        chk("t4_after_req", 32'(o_dmem_req), 32'd0);
        chk("t4_after_stall", 32'(o_MEM_stall), 32'd0);
        tick();

        // 5. Misaligned store; the unchecked instance issues it normally.
        drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0102, 32'h0000_0011);
        push(1'b1, 5'd2, 32'd0);
        tick();
        idle();
        i_dmem_ack = 1'b1;
        @(negedge clk);
        chk("t5_req", 32'(o_dmem_req), 32'd0);
        chk("t5_err", 32'(o_MEM_err), 32'd1);
        chk("t5_stall", 32'(o_MEM_stall), 32'd0);
        chk("t5_na_req", 32'(na_dmem_req), 32'd1);
        chk("t5_na_addr", na_dmem_addr, 32'h0000_0102);
        chk("t5_na_err", 32'(na_MEM_err), 32'd0);
        tick();
        i_dmem_ack = 1'b0;
        @(negedge clk);
        chk("t5_err_pulse", 32'(o_MEM_err), 32'd0);
        tick();

        // 6. Reset during WAIT after two wait cycles.
        drive(1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0300, 32'd0);
        tick();
        idle();
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_req", 32'(o_dmem_req), 32'd0);
        chk("t6_rst_stall", 32'(o_MEM_stall), 32'd0);
        chk("t6_rst_regwe", 32'(o_MEM_regWe), 32'd0);
        chk("t6_rst_err", 32'(o_MEM_err), 32'd0);
        tick();
        #2 rstn = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 5'd8, 32'h0000_0104, 32'd0);
        push(1'b0, 5'd8, 32'h0BAD_F00D);
        tick();
        idle();
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("t6_req", 32'(o_dmem_req), 32'd1);
        chk("t6_stall", 32'(o_MEM_stall), 32'd0);
        tick();
        i_dmem_ack = 1'b0;
        @(negedge clk);
        chk("t6_done_regwe", 32'(o_MEM_regWe), 32'd0);
        tick();
        tick();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
